flaw_alarm_detect: RTL

Echo-threshold detector sitting directly upstream of the buzzer driver. It consumes the digitised echo sample stream inside a measurement gate and compares each sample against a programmable threshold. When a run of consecutive over-threshold samples confirms a flaw, it issues the one-cycle `alarm_en` trigger the buzzer consumes. Each gate ends with a peak/flaw summary; a holdoff timer rate-limits alarms.

---
 rtl/flaw_alarm_detect.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/flaw_alarm_detect.sv
// flaw_alarm_detect
// -----------------
// Echo-threshold detector that feeds the buzzer driver. Inside a measurement
// gate, each valid echo sample is compared against a threshold latched at the
// gate start. A run of CONFIRM_N consecutive over-threshold samples confirms a
// flaw and fires a one-cycle alarm_en, rate-limited by a holdoff timer that
// runs independently of the gates. Each gate ends with a peak/flaw summary.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   gate_start    one-cycle pulse opening a gate (accepted only while idle)
//   gate_len      number of valid samples in the gate, latched with gate_start
//   threshold     unsigned compare level, latched with gate_start
//   sample_valid  qualifies sample_data
//   sample_data   unsigned echo amplitude
//   alarm_en      one-cycle flaw trigger to the buzzer
//   result_valid  one-cycle pulse, summary outputs updated on the same edge
//   flaw_detected flaw confirmed in the last completed gate
//   peak_value    maximum sample of the last completed gate
//   peak_index    0-based index of the first occurrence of that maximum
//   busy          high while a gate is open
module flaw_alarm_detect #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned CONFIRM_N = 4,
    parameter logic [31:0] HOLDOFF   = 32'd100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gate_start,
    input  logic [15:0]       gate_len,
    input  logic [DATA_W-1:0] threshold,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              alarm_en,
    output logic              result_valid,
    output logic              flaw_detected,
    output logic [DATA_W-1:0] peak_value,
    output logic [15:0]       peak_index,
    output logic              busy
);

    localparam int unsigned      RUN_W   = $clog2(CONFIRM_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CONFIRM_N);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GATE = 1'b1;

    logic [0:0]        state;
    logic [15:0]       len_q;
    logic [15:0]       cnt_q;
    logic [DATA_W-1:0] thr_q;
    logic [DATA_W-1:0] peak_q;
    logic [15:0]       idx_q;
    logic [RUN_W-1:0]  run_q;
    logic              flaw_q;
    logic              fired_q;
    logic [31:0]       holdoff_q;

    logic              over;
    logic              confirm;
    logic              peak_upd;
    logic              last_sample;
    logic [RUN_W-1:0]  run_next;
    logic [15:0]       cnt_next;

    // Per-sample decisions, evaluated against the current sample.
    always_comb begin
        over = (sample_data > thr_q);
        if (!over) begin
            run_next = '0;
        end else if (run_q == RUN_MAX) begin
            run_next = RUN_MAX;
        end else begin
            run_next = run_q + 1'b1;
        end
        // Confirmation is the transition into CONFIRM_N, not staying saturated,
        // so a run that was held off can never fire a late alarm.
        confirm     = over && (run_q != RUN_MAX) && (run_next == RUN_MAX);
        peak_upd    = (sample_data > peak_q);
        cnt_next    = cnt_q + 16'd1;
        last_sample = (cnt_next == len_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, including the summary outputs, is reset so
            // the block comes out of reset with all outputs at 0.
            state         <= ST_IDLE;
            len_q         <= '0;
            cnt_q         <= '0;
            thr_q         <= '0;
            peak_q        <= '0;
            idx_q         <= '0;
            run_q         <= '0;
            flaw_q        <= 1'b0;
            fired_q       <= 1'b0;
            holdoff_q     <= '0;
            alarm_en      <= 1'b0;
            result_valid  <= 1'b0;
            flaw_detected <= 1'b0;
            peak_value    <= '0;
            peak_index    <= '0;
        end else begin
            // NOTE: pulses default low here; a later non-blocking assignment in
            // this same block overrides the default for that cycle.
            alarm_en     <= 1'b0;
            result_valid <= 1'b0;

            if (holdoff_q != 32'd0) begin
                holdoff_q <= holdoff_q - 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (gate_start) begin
                        len_q   <= gate_len;
                        thr_q   <= threshold;
                        run_q   <= '0;
                        cnt_q   <= '0;
                        peak_q  <= '0;
                        idx_q   <= '0;
                        flaw_q  <= 1'b0;
                        fired_q <= 1'b0;
                        if (gate_len == 16'd0) begin
                            // Empty gate: immediate all-zero summary.
                            result_valid  <= 1'b1;
                            flaw_detected <= 1'b0;
                            peak_value    <= '0;
                            peak_index    <= '0;
                        end else begin
                            state <= ST_GATE;
                        end
                    end
                end

                ST_GATE: begin
                    if (sample_valid) begin
                        run_q <= run_next;
                        cnt_q <= cnt_next;
                        if (peak_upd) begin
                            peak_q <= sample_data;
                            idx_q  <= cnt_q;
                        end
                        if (confirm) begin
                            flaw_q <= 1'b1;
                            // Holdoff is only loaded when it is already 0, so
                            // this load never collides with the decrement.
                            if ((holdoff_q == 32'd0) && !fired_q) begin
                                alarm_en  <= 1'b1;
                                holdoff_q <= HOLDOFF;
                                fired_q   <= 1'b1;
                            end
                        end
                        if (last_sample) begin
                            // The final sample itself may set the peak or the flaw.
                            result_valid  <= 1'b1;
                            flaw_detected <= flaw_q | confirm;
                            peak_value    <= peak_upd ? sample_data : peak_q;
                            peak_index    <= peak_upd ? cnt_q : idx_q;
                            state         <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_GATE);

endmodule
